// File: rtl/clk_div_bank_if.sv
// Configuration port of clk_div_bank: one-cycle write strobe carrying
// channel/divisor/phase, answered by a one-cycle acknowledge.
interface clk_div_bank_if #(
    parameter int CH_W  = 2,
    parameter int DIV_W = 8
);
    logic             cfg_wr;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic [DIV_W-1:0] cfg_phase;
    logic             cfg_ack;

    modport master (output cfg_wr, cfg_ch, cfg_div, cfg_phase, input cfg_ack);
    modport slave  (input cfg_wr, cfg_ch, cfg_div, cfg_phase, output cfg_ack);
endinterface

// File: rtl/clk_div_bank.sv
// Multi-channel clock-enable generator with glitch-free retuning and lock flag.
// Optional realign input enabled by defining CLKDIV_SYNC_EN.
module clk_div_ch #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             wr,
    input  logic [DIV_W-1:0] wdiv,
    input  logic [DIV_W-1:0] wphase,
    input  logic             sync_evt,
    output logic             outclk,
    output logic             outstb,
    output logic             applied
);
    logic [DIV_W-1:0] d_q, d_d, c_q, c_d, sd_q, sd_d, sp_q, sp_d;
    logic             pend_q, pend_d, outclk_q, outclk_d, outstb_q, outstb_d;
    logic             wrap;

    always_comb begin
        wrap     = (c_q == d_q - 1'b1);
        applied  = pend_q & wrap & ~sync_evt;
        d_d      = d_q;
        c_d      = wrap ? '0 : c_q + 1'b1;
        sd_d     = sd_q;
        sp_d     = sp_q;
        pend_d   = pend_q;
        if (sync_evt) begin
            if (pend_q) begin
                d_d = sd_q;
                c_d = sp_q;
            end else begin
                c_d = '0;
            end
            pend_d = 1'b0;
        end else if (pend_q && wrap) begin
            // Swap only at the period boundary so no runt pulse escapes
            d_d    = sd_q;
            c_d    = sp_q;
            pend_d = 1'b0;
        end
        // A write in the apply cycle lands after the old shadow was consumed
        if (wr) begin
            sd_d   = wdiv;
            sp_d   = wphase;
            pend_d = 1'b1;
        end
        outclk_d = (c_q < (d_q >> 1));
        outstb_d = (c_q == '0);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            d_q      <= DIV_W'(DEFAULT_DIV);
            c_q      <= '0;
            sd_q     <= DIV_W'(DEFAULT_DIV);
            sp_q     <= '0;
            pend_q   <= 1'b0;
            outclk_q <= 1'b0;
            outstb_q <= 1'b0;
        end else begin
            d_q      <= d_d;
            c_q      <= c_d;
            sd_q     <= sd_d;
            sp_q     <= sp_d;
            pend_q   <= pend_d;
            outclk_q <= outclk_d;
            outstb_q <= outstb_d;
        end
    end

    assign outclk = outclk_q;
    assign outstb = outstb_q;
endmodule

module clk_div_bank #(
    parameter int NUM_CH      = 3,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 4,
    parameter int LOCK_CYCLES = 16
) (
    input  logic              refclk,
    input  logic              rst,
    clk_div_bank_if.slave     cfg,
`ifdef CLKDIV_SYNC_EN
    input  logic              sync,
`endif
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] outstb,
    output logic              locked
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LOCK_W = 16;

    logic [DIV_W-1:0]  div_eff, phase_eff;
    logic              wr_ok, sync_evt, lock_clr;
    logic [NUM_CH-1:0] wr_vec, applied_vec;
    logic              ack_q, ack_d, locked_q, locked_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;

`ifdef CLKDIV_SYNC_EN
    logic sync_q, sync_d, sync_dly_q, sync_dly_d;

    always_comb begin
        sync_d     = sync;
        sync_dly_d = sync_q;
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_q     <= 1'b0;
            sync_dly_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            sync_dly_q <= sync_dly_d;
        end
    end

    assign sync_evt = sync_q & ~sync_dly_q;
`else
    assign sync_evt = 1'b0;
`endif

    always_comb begin
        div_eff   = (cfg.cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg.cfg_div;
        phase_eff = (cfg.cfg_phase >= div_eff) ? '0 : cfg.cfg_phase;
        wr_ok     = cfg.cfg_wr && (32'(cfg.cfg_ch) < NUM_CH);
        for (int i = 0; i < NUM_CH; i++) begin
            wr_vec[i] = wr_ok && (cfg.cfg_ch == CH_W'(i));
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_ch #(
            .DIV_W      (DIV_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .refclk  (refclk),
            .rst     (rst),
            .wr      (wr_vec[i]),
            .wdiv    (div_eff),
            .wphase  (phase_eff),
            .sync_evt(sync_evt),
            .outclk  (outclk[i]),
            .outstb  (outstb[i]),
            .applied (applied_vec[i])
        );
    end

    always_comb begin
        lock_clr = (|applied_vec) | sync_evt;
        ack_d    = wr_ok;
        if (lock_clr)
            lock_cnt_d = '0;
        else if (lock_cnt_q < LOCK_W'(LOCK_CYCLES))
            lock_cnt_d = lock_cnt_q + 1'b1;
        else
            lock_cnt_d = lock_cnt_q;
        locked_d = (lock_cnt_d >= LOCK_W'(LOCK_CYCLES));
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            ack_q      <= 1'b0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            ack_q      <= ack_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign cfg.cfg_ack = ack_q;
    assign locked      = locked_q;
endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank (3 channels, default div 4, lock 16).
module tb_clk_div_bank;
    localparam int NUM_CH = 3;
    localparam int DIV_W  = 8;
    localparam int CH_W   = 2;

    logic              refclk = 1'b0;
    logic              rst    = 1'b1;
    logic [NUM_CH-1:0] outclk, outstb;
    logic              locked;
`ifdef CLKDIV_SYNC_EN
    logic              sync = 1'b0;
`endif
    int n_pass = 0;
    int n_chk  = 0;
    int n      = 0;

    clk_div_bank_if #(.CH_W(CH_W), .DIV_W(DIV_W)) bus ();

    clk_div_bank #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(4), .LOCK_CYCLES(16)
    ) dut (
        .refclk(refclk),
        .rst   (rst),
        .cfg   (bus),
`ifdef CLKDIV_SYNC_EN
        .sync  (sync),
`endif
        .outclk(outclk),
        .outstb(outstb),
        .locked(locked)
    );

    always #5 refclk = ~refclk;

    task automatic tick();
        @(posedge refclk);
        #1;
        n++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s at n=%0d: got %0h expected %0h", tag, n, obs, exp);
    endtask

    task automatic cfg_set(input logic wr, input int ch, input int dv, input int ph);
        bus.cfg_wr    = wr;
        bus.cfg_ch    = CH_W'(ch);
        bus.cfg_div   = DIV_W'(dv);
        bus.cfg_phase = DIV_W'(ph);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cfg_set(1'b0, 0, 0, 0);
        repeat (3) tick();
        chk("rst_outclk", 32'(outclk), 0);
        chk("rst_outstb", 32'(outstb), 0);
        chk("rst_ack",    32'(bus.cfg_ack), 0);
        chk("rst_locked", 32'(locked), 0);
        rst = 1'b0;
        n   = -1;
    endtask

    // Expected waveform k cycles into a period of divisor d
    function automatic logic dclk(input int k, input int d);
        return (k % d) < (d / 2);
    endfunction
    function automatic logic dstb(input int k, input int d);
        return (k % d) == 0;
    endfunction

    logic [2:0] ec, es;

    initial begin
        // Reset defaults: 1100 on every channel, lock after 16 cycles
        do_reset();
        while (n < 15) begin
            tick();
            chk("t1_clk",  32'(outclk), 32'({3{dclk(n, 4)}}));
            chk("t1_stb",  32'(outstb), 32'({3{dstb(n, 4)}}));
            chk("t1_lock", 32'(locked), 32'(n >= 15));
        end

        // Retune ch1 to div 10 while its counter is 1
        do_reset();
        while (n < 40) begin
            tick();
            if (n == 16) cfg_set(1'b1, 1, 10, 0);
            else         cfg_set(1'b0, 0, 0, 0);
            ec = {dclk(n, 4), (n < 20) ? dclk(n, 4) : dclk(n - 20, 10), dclk(n, 4)};
            es = {dstb(n, 4), (n < 20) ? dstb(n, 4) : dstb(n - 20, 10), dstb(n, 4)};
            chk("t2_clk",  32'(outclk), 32'(ec));
            chk("t2_stb",  32'(outstb), 32'(es));
            chk("t2_ack",  32'(bus.cfg_ack), 32'(n == 17));
            chk("t2_lock", 32'(locked), 32'((n >= 15) && !(n >= 19 && n <= 34)));
        end

        // Divisor clamp, phase clamp, out-of-range channel
        do_reset();
        while (n < 26) begin
            tick();
            case (n)
                0:       cfg_set(1'b1, 0, 1, 0);
                4:       cfg_set(1'b1, 2, 5, 7);
                9:       cfg_set(1'b1, 3, 2, 0);
                default: cfg_set(1'b0, 0, 0, 0);
            endcase
            ec = {(n < 8) ? dclk(n, 4) : dclk(n - 8, 5), dclk(n, 4), (n < 4) ? dclk(n, 4) : dclk(n, 2)};
            es = {(n < 8) ? dstb(n, 4) : dstb(n - 8, 5), dstb(n, 4), (n < 4) ? dstb(n, 4) : dstb(n, 2)};
            chk("t3_clk",  32'(outclk), 32'(ec));
            chk("t3_stb",  32'(outstb), 32'(es));
            chk("t3_ack",  32'(bus.cfg_ack), 32'(n == 1 || n == 5));
            chk("t3_lock", 32'(locked), 32'(n >= 23));
        end

        // Two writes to ch2 before its wrap: div 8 wins
        do_reset();
        while (n < 21) begin
            tick();
            if (n == 0)      cfg_set(1'b1, 2, 6, 0);
            else if (n == 1) cfg_set(1'b1, 2, 8, 0);
            else             cfg_set(1'b0, 0, 0, 0);
            ec = {(n < 4) ? dclk(n, 4) : dclk(n - 4, 8), dclk(n, 4), dclk(n, 4)};
            es = {(n < 4) ? dstb(n, 4) : dstb(n - 4, 8), dstb(n, 4), dstb(n, 4)};
            chk("t4_clk",  32'(outclk), 32'(ec));
            chk("t4_stb",  32'(outstb), 32'(es));
            chk("t4_ack",  32'(bus.cfg_ack), 32'(n == 1 || n == 2));
            chk("t4_lock", 32'(locked), 32'(n >= 19));
        end

`ifdef CLKDIV_SYNC_EN
        // Channels at 3/5/7, then a sync pulse realigns them
        do_reset();
        while (n < 50) begin
            tick();
            case (n)
                0:       cfg_set(1'b1, 0, 3, 0);
                1:       cfg_set(1'b1, 1, 5, 0);
                2:       cfg_set(1'b1, 2, 7, 0);
                default: cfg_set(1'b0, 0, 0, 0);
            endcase
            sync = (n == 29);
            if (n >= 30)
                chk("t5_lock", 32'(locked), 32'(!(n >= 31 && n <= 46)));
            if (n >= 32) begin
                ec = {dclk(n - 32, 7), dclk(n - 32, 5), dclk(n - 32, 3)};
                es = {dstb(n - 32, 7), dstb(n - 32, 5), dstb(n - 32, 3)};
                chk("t5_clk", 32'(outclk), 32'(ec));
                chk("t5_stb", 32'(outstb), 32'(es));
            end
        end
`endif

        // Reset while ch0 has an update pending: it must be dropped
        do_reset();
        tick();
        cfg_set(1'b1, 0, 10, 0);
        tick();
        cfg_set(1'b0, 0, 0, 0);
        chk("t6_ack", 32'(bus.cfg_ack), 1);
        do_reset();
        while (n < 12) begin
            tick();
            chk("t6_clk", 32'(outclk), 32'({3{dclk(n, 4)}}));
            chk("t6_stb", 32'(outstb), 32'({3{dstb(n, 4)}}));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised multi-channel clock-enable generator running on the board reference clock. It produces NUM_CH divided clocks with per-channel strobes, runtime-programmable divide ratio and phase, glitch-free retuning and a `locked` indication. It sits beside the fixed PLL outputs and supplies slow derived timebases without consuming another PLL.

## Interface

- `NUM_CH`, 3: number of output channels, 1..16.
- `DIV_W`, 8: width of divisor, phase and channel counters.
- `DEFAULT_DIV`, 4: divisor loaded into every channel at reset, 2..2^DIV_W-1.
- `LOCK_CYCLES`, 16: stable `refclk` cycles required before `locked` rises, 1..65535.
- `CH_W` (derived): `max(1, clog2(NUM_CH))`.

- `refclk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `cfg_wr` in 1: one-cycle configuration write strobe.
- `cfg_ch` in CH_W: target channel.
- `cfg_div` in DIV_W: new divisor.
- `cfg_phase` in DIV_W: counter value loaded when the update is applied.
- `cfg_ack` out 1: one-cycle pulse, the cycle after a valid write is accepted.
- `sync` in 1: realign request. Present only with `CLKDIV_SYNC_EN`.
- `outclk` out NUM_CH: divided clocks, registered.
- `outstb` out NUM_CH: one-cycle strobe coinciding with each `outclk` rising edge.
- `locked` out 1: all channels stable for LOCK_CYCLES.

## Operation

- **Per-channel state:** active divisor `D`, counter `c` (0..D-1), shadow divisor/phase, `pend` flag.
- **Counter:** `c` increments every cycle and wraps from D-1 to 0.
- **Outputs:** derived from `c`.
  - `outclk[i]` = (c < D>>1). High for floor(D/2) cycles, low for ceil(D/2) cycles.
  - `outstb[i]` = (c == 0).
- **Divisor clamp:** `cfg_div` < 2 is stored as 2.
- **Phase clamp:** `cfg_phase` ≥ effective new divisor is stored as 0.
- **Valid write** (`cfg_wr` and `cfg_ch` < NUM_CH):
  - the channel's shadow registers are loaded and `pend` is set;
  - `cfg_ack` pulses.
  - A second write before apply overwrites the shadow (last wins), and is acked again.
- **Invalid write** (`cfg_ch` ≥ NUM_CH): ignored, no `cfg_ack`.
- **Apply:** in the cycle where the channel has `pend` set and c == D-1, the channel loads D ← shadow divisor and c ← shadow phase, and clears `pend`. The current period always completes, so no runt pulse is produced.
- **Simultaneous write and apply:** if a write lands in the apply cycle for the same channel, the old shadow is applied and the new write becomes pending.
- **Lock counter:** a saturating counter, cleared in any cycle where any channel applies an update (or on sync). `locked` = counter ≥ LOCK_CYCLES.
- **Reset:**
  - every channel: D = DEFAULT_DIV, c = 0, `pend` = 0;
  - outputs: `outclk` = 0, `outstb` = 0, `cfg_ack` = 0, `locked` = 0;
  - lock counter = 0.
  - `rst` overrides any concurrent `cfg_wr` or `sync`. A pending update is discarded.

## Timing

- **Output latency:** outputs are registered, so `outclk[i]`/`outstb[i]` in cycle t+1 reflect c(t).
- **After reset:** first `outstb` appears 1 cycle after `rst` falls, because c = 0 in the first non-reset cycle.
- **`cfg_ack`:** 1 cycle after the write.
- **Update apply:** takes effect within at most old-D cycles. The new waveform starts the cycle after apply: c = phase is visible on outputs at t+1.
- **`locked` fall:** drops in the cycle after an apply.
- **`locked` rise:** after reset or the last apply, rises after exactly LOCK_CYCLES cycles with no further apply. It is then held until the next apply, sync or reset.

## Configuration

- **Macro:** `CLKDIV_SYNC_EN`.
- **Defined:**
  - the `sync` port exists and is registered, with rising-edge detect (2-cycle latency from pin to action);
  - on a detected edge, every channel immediately loads its pending shadow if `pend` is set, otherwise keeps D;
  - c ← phase (shadow phase if pending, else 0); `pend` clears and the lock counter clears.
  - Channels are phase-aligned after sync regardless of their previous positions.
  - Sync in the same cycle as a channel's natural apply is treated as the sync.
- **Undefined:** the port is absent, with no edge-detect logic. Behaviour is otherwise identical.

## Test plan

- **Reset defaults:** reset with defaults (DEFAULT_DIV=4) -> all channels: `outclk` 1100 repeating, `outstb` every 4 cycles, all aligned; `locked` rises 16 cycles after `rst` falls.
- **Retune, no runt:** write ch1 div=10 phase=0 while ch1 c=1 -> `cfg_ack` next cycle; ch1 completes its 4-cycle period, then 5-high/5-low; no pulse shorter than 2 cycles; `locked` drops, then returns after 16 cycles.
- **Clamps and invalid channel:**
  - div=1 on ch0 -> runs as div 2;
  - phase=7 with div=5 -> phase 0;
  - write to ch=3 (NUM_CH=3) -> no ack, no change.
- **Last write wins:** two writes to ch2 (div=6, then div=8) before wrap -> two acks; only div 8 is applied.
- **Sync (`CLKDIV_SYNC_EN`):** channels at div 3/5/7 free-running; pulse `sync` -> 2 cycles later all `outstb` assert together, and `locked` re-qualifies.
- **Reset mid-pending:** `rst` asserted with ch0 pending -> after reset ch0 uses DEFAULT_DIV and `pend` = 0.
